// File: rtl/bram_rd_capture_fifo.sv
// ---------------------------------------------------------------------------
// bram_rd_capture_fifo
//
// Purpose:
//   Turns BRAM Port-B read data into a valid/ready stream for the compute
//   array. A RD_LATENCY-deep valid/tag pipe tracks each bram_en, so doutb is
//   captured in the cycle it is valid. Captured words go into a show-ahead
//   FIFO, and the final word of each tile is tagged. fetch_hold rises early
//   enough for upstream to stop before a word can be lost.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bram_en       read issued to the BRAM this cycle
//   fetch_done    tile-done pulse, coincident with the tile's final bram_en
//   doutb         BRAM Port-B read data (not pipelined here)
//   flush         synchronous clear of FIFO, pipe and tags (errors kept)
//   m_valid/m_ready/m_data/m_last   output stream to the compute array
//   fetch_hold    ask upstream to stop issuing reads
//   ovf_err       sticky: a captured word was dropped because the FIFO was full
//   tag_err       sticky: fetch_done was seen without bram_en
//
// Optional feature (macro RD_CAPTURE_STATS_EN):
//   words_out[15:0]  popped-word counter (wraps)
//   tiles_out[7:0]   popped m_last counter (wraps)
//   Both counters are cleared by rst and by flush.
//
// Handshake: a word transfers on any rising edge where m_valid && m_ready.
//   m_valid never depends on m_ready. m_data and m_last hold steady while
//   m_valid is high and m_ready is low.
// ---------------------------------------------------------------------------
module bram_rd_capture_fifo #(
    parameter int DATA_WIDTH  = 256,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bram_en,
    input  logic                  fetch_done,
    input  logic [DATA_WIDTH-1:0] doutb,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  fetch_hold,
    output logic                  ovf_err,
    output logic                  tag_err
`ifdef RD_CAPTURE_STATS_EN
    ,
    output logic [15:0]           words_out,
    output logic [7:0]            tiles_out
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] last_pipe;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic        empty;
    logic        full;
    logic        cap_vld;
    logic        cap_last;
    logic        push;
    logic        pop;
    logic        drop;
    logic [31:0] inflight;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign cap_vld  = vld_pipe[RD_LATENCY-1];
    assign cap_last = last_pipe[RD_LATENCY-1];

    // flush overrides both push and pop. A full FIFO still accepts a word
    // when it is popping in the same cycle.
    assign pop  = !empty && m_ready && !flush;
    assign push = cap_vld && !flush && (!full || pop);
    assign drop = cap_vld && !flush && full && !pop;

    // Show-ahead head. The output reads as zero while empty, so reset gives
    // all-zero outputs without having to clear the storage array.
    assign m_valid = !empty;
    assign m_data  = empty ? '0 : mem_data[rd_ptr];
    assign m_last  = !empty && mem_last[rd_ptr];

    // Reads still in the BRAM pipeline have already claimed a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 32'(vld_pipe[i]);
        end
    end

    assign fetch_hold = (32'(count) + inflight) >= 32'(FIFO_DEPTH - HOLD_MARGIN);

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= doutb;
            mem_last[wr_ptr] <= cap_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_err   <= 1'b0;
            tag_err   <= 1'b0;
`ifdef RD_CAPTURE_STATS_EN
            words_out <= '0;
            tiles_out <= '0;
`endif
        end else begin
            tag_err <= tag_err | (fetch_done & ~bram_en);
            ovf_err <= ovf_err | drop;
            if (flush) begin
                // A read issued during the flush cycle is discarded too.
                vld_pipe  <= '0;
                last_pipe <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
`ifdef RD_CAPTURE_STATS_EN
                words_out <= '0;
                tiles_out <= '0;
`endif
            end else begin
                vld_pipe[0]  <= bram_en;
                last_pipe[0] <= bram_en & fetch_done;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    vld_pipe[i]  <= vld_pipe[i-1];
                    last_pipe[i] <= last_pipe[i-1];
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
`ifdef RD_CAPTURE_STATS_EN
                if (pop) begin
                    words_out <= words_out + 16'd1;
                    if (m_last) begin
                        tiles_out <= tiles_out + 8'd1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_capture_fifo.sv
// ---------------------------------------------------------------------------
// tb_bram_rd_capture_fifo
//
// Directed bench for bram_rd_capture_fifo with the default parameters
// (RD_LATENCY=2, FIFO_DEPTH=8, HOLD_MARGIN=2). A two-register BRAM model
// returns word_of(addr) two edges after each read. Expected words, each with
// its last tag, are queued as reads are issued. A negedge monitor compares
// every accepted output word against the head of that queue.
// ---------------------------------------------------------------------------
module tb_bram_rd_capture_fifo;

    localparam int DW = 256;
    typedef logic [DW-1:0] word_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT signals
    logic          bram_en;
    logic          fetch_done;
    word_t         doutb;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    word_t         m_data;
    logic          m_last;
    logic          fetch_hold;
    logic          ovf_err;
    logic          tag_err;

    int            addr;
    word_t         bram_d1;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {last, data}.
    logic [DW:0] exp_q[$];

    bram_rd_capture_fifo #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (2),
        .FIFO_DEPTH (8),
        .HOLD_MARGIN(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bram_en   (bram_en),
        .fetch_done(fetch_done),
        .doutb     (doutb),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .fetch_hold(fetch_hold),
        .ovf_err   (ovf_err),
        .tag_err   (tag_err)
    );

    function automatic word_t word_of(input int a);
        return {8{32'hC0DE_0000 + 32'(a)}};
    endfunction

    // BRAM Port-B model: two-cycle read latency.
    always @(posedge clk) begin
        bram_d1 <= word_of(addr);
        doutb   <= bram_d1;
    end

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted word must match the model queue head
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_with_empty_model", word_t'(m_valid), word_t'(0));
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("pop_data", m_data, e[DW-1:0]);
                check("pop_last", word_t'(m_last), word_t'(e[DW]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a, input bit last, input bit keep);
        bram_en    = 1'b1;
        fetch_done = last;
        addr       = a;
        if (keep) exp_q.push_back({last, word_of(a)});
        tick();
        bram_en    = 1'b0;
        fetch_done = 1'b0;
    endtask

    task automatic idle(input int n);
        bram_en    = 1'b0;
        fetch_done = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"},    word_t'(m_valid),    word_t'(0));
        check({tag, "_m_data"},     m_data,              word_t'(0));
        check({tag, "_m_last"},     word_t'(m_last),     word_t'(0));
        check({tag, "_fetch_hold"}, word_t'(fetch_hold), word_t'(0));
        check({tag, "_ovf_err"},    word_t'(ovf_err),    word_t'(0));
        check({tag, "_tag_err"},    word_t'(tag_err),    word_t'(0));
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        bram_en    = 1'b0;
        fetch_done = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        addr       = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1) four back-to-back reads, last tagged on the 4th
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(i, (i == 3), 1'b1);
            if (i == 1) check("t1_latency_not_yet", word_t'(m_valid), word_t'(0));
            if (i == 2) begin
                check("t1_latency_valid", word_t'(m_valid), word_t'(1));
                check("t1_first_word", m_data, word_of(0));
            end
        end
        idle(6);
        check("t1_drained", word_t'(exp_q.size()), word_t'(0));
        check("t1_idle_valid", word_t'(m_valid), word_t'(0));

        // 2) stall, issue until fetch_hold, then drain
        m_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (fetch_hold) break;
            issue(10 + n, 1'b0, 1'b1);
            n++;
        end
        check("t2_reads_before_hold", word_t'(n), word_t'(6));
        idle(4);
        check("t2_hold_high", word_t'(fetch_hold), word_t'(1));
        check("t2_no_ovf", word_t'(ovf_err), word_t'(0));
        check("t2_head", m_data, word_of(10));
        m_ready = 1'b1;
        idle(10);
        check("t2_drained", word_t'(exp_q.size()), word_t'(0));
        check("t2_hold_low", word_t'(fetch_hold), word_t'(0));

        // 4) full FIFO, push+pop in the same cycle for 5 cycles
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) issue(200 + i, 1'b0, 1'b1);
        idle(3);
        check("t4_full_hold", word_t'(fetch_hold), word_t'(1));
        check("t4_full_head", m_data, word_of(200));
        for (int i = 0; i < 5; i++) begin
            if (i == 2) m_ready = 1'b1;
            if (i == 4) check("t4_hold_while_full", word_t'(fetch_hold), word_t'(1));
            issue(208 + i, (i == 4), 1'b1);
        end
        idle(16);
        check("t4_drained", word_t'(exp_q.size()), word_t'(0));
        check("t4_no_ovf", word_t'(ovf_err), word_t'(0));

        // 3) ignore fetch_hold: 10 reads, 8 kept, 2 dropped
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) issue(400 + i, 1'b0, (i < 8));
        idle(4);
        check("t3_ovf_set", word_t'(ovf_err), word_t'(1));
        check("t3_head", m_data, word_of(400));
        m_ready = 1'b1;
        idle(12);
        check("t3_drained", word_t'(exp_q.size()), word_t'(0));
        check("t3_empty", word_t'(m_valid), word_t'(0));

        // 5) orphan fetch_done, then flush mid-stream
        check("t5_tag_err_clear", word_t'(tag_err), word_t'(0));
        issue(500, 1'b0, 1'b1);
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
        check("t5_tag_err_set", word_t'(tag_err), word_t'(1));
        idle(5);
        check("t5_untagged_drained", word_t'(exp_q.size()), word_t'(0));
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(600 + i, 1'b0, 1'b0);
        check("t5_mid_stream_valid", word_t'(m_valid), word_t'(1));
        flush   = 1'b1;
        bram_en = 1'b1;
        addr    = 604;
        tick();
        flush   = 1'b0;
        bram_en = 1'b0;
        check("t5_flush_valid", word_t'(m_valid), word_t'(0));
        m_ready = 1'b1;
        idle(4);
        check("t5_flush_pipe_cleared", word_t'(m_valid), word_t'(0));
        check("t5_flush_hold", word_t'(fetch_hold), word_t'(0));
        check("t5_tag_err_kept", word_t'(tag_err), word_t'(1));

        // 6) reset with two reads in flight
        m_ready = 1'b0;
        issue(700, 1'b0, 1'b0);
        issue(701, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("t6_async_rst");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        idle(6);
        check("t6_no_words", word_t'(m_valid), word_t'(0));
        check("t6_ovf_clear", word_t'(ovf_err), word_t'(0));
        check("t6_model_empty", word_t'(exp_q.size()), word_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
